// File: rtl/readout_pkg.sv
// Shared types and sizing for the capture readout controller.
package readout_pkg;
  localparam int DEPTH  = 102400;
  localparam int ADDR_W = 17;
  localparam int DATA_W = 16;
  localparam int RD_LAT = 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACQ = 2'd1,
    READ     = 2'd2,
    DRAIN    = 2'd3
  } state_t;
endpackage

// File: rtl/readout_skid_buffer.sv
// Two-entry valid/ready buffer between the memory read pipeline and the consumer.
module readout_skid_buffer #(
  parameter int WIDTH = readout_pkg::DATA_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       level
);
  import readout_pkg::*;

  logic [WIDTH-1:0] mem [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic             push;
  logic             pop;

  assign in_ready  = (level != 2'd2);
  assign out_valid = (level != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Head entry is a register, so the presented beat cannot change while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      level  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      level  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   level <= level + 2'd1;
        2'b01:   level <= level - 2'd1;
        default: level <= level;
      endcase
    end
  end
endmodule

// File: rtl/capture_readout_controller.sv
// Reads a circular sample memory and streams it to a valid/ready consumer.
// Optional READOUT_DECIMATE_EN adds a decim input (address stride = decim+1).
module capture_readout_controller #(
  parameter int DEPTH  = readout_pkg::DEPTH,
  parameter int ADDR_W = readout_pkg::ADDR_W,
  parameter int DATA_W = readout_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] num_samples,
  input  logic              acq_busy,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
`ifdef READOUT_DECIMATE_EN
  input  logic [3:0]        decim,
`endif
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);
  import readout_pkg::*;

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] issue_left;
  logic [ADDR_W-1:0] num_clamped;
  logic [4:0]        stride;
  logic              vld_p1;
  logic              last_p1;
  logic              done_q;
  logic              cfg_err_q;
  logic              start_req;
  logic              start_ok;
  logic              aborting;
  logic              out_hs;
  logic              can_issue;
  logic [2:0]        pending;
  logic [1:0]        level;
  logic              skid_in_ready;
  logic [DATA_W:0]   skid_out;

  function automatic logic [ADDR_W-1:0] wrap_addr(input logic [ADDR_W-1:0] addr,
                                                  input logic [4:0]        step);
    logic [ADDR_W:0] sum;
    sum = {1'b0, addr} + {{(ADDR_W-4){1'b0}}, step};
    if (sum >= {1'b0, DEPTH_A}) begin
      sum = sum - {1'b0, DEPTH_A};
    end
    return sum[ADDR_W-1:0];
  endfunction

  assign start_req   = start && !abort && (state == IDLE);
  assign start_ok    = start_req && (start_addr < DEPTH_A) && (num_samples != '0);
  assign aborting    = abort && (state != IDLE);
  assign out_hs      = out_valid && out_ready;
  assign num_clamped = (num_samples > DEPTH_A) ? DEPTH_A : num_samples;
  // A beat leaving this cycle frees its slot, which keeps one beat per cycle.
  assign pending     = 3'(level) + 3'(vld_p1) - 3'(out_hs);
  assign can_issue   = (issue_left != '0) && (pending < 3'd2);
  assign mem_rd_addr = rd_addr;
  assign busy        = (state != IDLE);
  assign done        = done_q;
  assign cfg_err     = cfg_err_q;

`ifdef READOUT_DECIMATE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stride <= 5'd1;
    end else if (start_ok) begin
      stride <= {1'b0, decim} + 5'd1;
    end
  end
`else
  assign stride = 5'd1;
`endif

  always_comb begin
    next_state = state;
    mem_rd_en  = 1'b0;
    case (state)
      IDLE:     if (start_ok) next_state = WAIT_ACQ;
      WAIT_ACQ: if (!acq_busy) next_state = READ;
      READ: begin
        mem_rd_en = can_issue;
        if (can_issue && (issue_left == ONE_A)) next_state = DRAIN;
      end
      DRAIN:    if (out_hs && out_last) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
    if (aborting) begin
      next_state = IDLE;
      mem_rd_en  = 1'b0;
    end
  end

  // Stage p0 -> p1: read issued, data returns from memory next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rd_addr    <= '0;
      issue_left <= '0;
      vld_p1     <= 1'b0;
      last_p1    <= 1'b0;
      done_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state     <= next_state;
      vld_p1    <= mem_rd_en;
      last_p1   <= mem_rd_en && (issue_left == ONE_A);
      cfg_err_q <= start_req && (start_addr >= DEPTH_A);
      done_q    <= (start_req && (start_addr < DEPTH_A) && (num_samples == '0))
                || (out_hs && out_last && (state != IDLE) && !aborting);
      if (start_ok) begin
        rd_addr    <= start_addr;
        issue_left <= num_clamped;
      end else if (mem_rd_en) begin
        rd_addr    <= wrap_addr(rd_addr, stride);
        issue_left <= issue_left - ONE_A;
      end
    end
  end

  // Stage p1 -> output: returned data plus its last flag enter the skid buffer.
  readout_skid_buffer #(
    .WIDTH (DATA_W + 1)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .flush     (aborting),
    .in_valid  (vld_p1 && skid_in_ready),
    .in_ready  (skid_in_ready),
    .in_data   ({last_p1, mem_rd_data}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (skid_out),
    .level     (level)
  );

  assign out_data = skid_out[DATA_W-1:0];
  assign out_last = out_valid && skid_out[DATA_W];
endmodule

// File: tb/tb_capture_readout_controller.sv
// Directed scoreboard bench for capture_readout_controller (honours READOUT_DECIMATE_EN).
module tb_capture_readout_controller;
  localparam int AW = 17;
  localparam int DW = 16;
  localparam int D  = 102400;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset, start, abort, acq_busy;
  logic [AW-1:0] start_addr, num_samples;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_rd_data;
  logic [DW-1:0] out_data;
  logic          out_valid, out_last, out_ready;
  logic          busy, done, cfg_err;
  logic [3:0]    decim_v = 4'd0;
  logic          rand_mode = 1'b0;
  logic          ready_lvl = 1'b1;
  logic          rnd_bit = 1'b0;
  logic          raise_acq = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rd_cnt, beat_cnt, done_cnt, cfg_cnt, busy_seen;
  int fr, fv, fhs, lhs, done_cyc, cfg_cyc;
  logic          prev_stall = 1'b0;
  logic [DW:0]   prev_beat = '0;

  logic [AW-1:0] addr_q[$];
  beat_t         beat_q[$];

  capture_readout_controller dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .start_addr  (start_addr),
    .num_samples (num_samples),
    .acq_busy    (acq_busy),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_last    (out_last),
    .out_ready   (out_ready),
`ifdef READOUT_DECIMATE_EN
    .decim       (decim_v),
`endif
    .busy        (busy),
    .done        (done),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;

  assign out_ready = rand_mode ? rnd_bit : ready_lvl;
  always @(posedge clk) rnd_bit <= 1'($urandom_range(0, 1));

  function automatic logic [DW-1:0] fdata(input logic [AW-1:0] a);
    return a[15:0] ^ {a[16], 15'h0} ^ 16'h3C5A;
  endfunction

  // Memory model: one-cycle read latency, garbage when not reading.
  always @(posedge clk) mem_rd_data <= mem_rd_en ? fdata(mem_rd_addr) : 16'hBAD0;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    rd_cnt = 0; beat_cnt = 0; done_cnt = 0; cfg_cnt = 0; busy_seen = 0;
    fr = -1; fv = -1; fhs = -1; lhs = -1; done_cyc = -1; cfg_cyc = -1;
    prev_stall = 1'b0;
  endtask

  task automatic do_start(input int a, input int n);
    int cnt;
    int stride;
    logic [AW-1:0] ad;
    beat_t b;
    start = 1'b1;
    start_addr = AW'(a);
    num_samples = AW'(n);
    stride = 1;
`ifdef READOUT_DECIMATE_EN
    stride = int'(decim_v) + 1;
`endif
    if (a >= D || n == 0) return;
    cnt = (n > D) ? D : n;
    ad = AW'(a);
    for (int i = 0; i < cnt; i++) begin
      addr_q.push_back(ad);
      b.data = fdata(ad);
      b.last = (i == cnt - 1);
      beat_q.push_back(b);
      ad = (int'(ad) + stride >= D) ? AW'(int'(ad) + stride - D) : AW'(int'(ad) + stride);
    end
  endtask

  // mode 0: fixed cycles, 1: until done, 2: until stop_beats beats accepted
  task automatic run(input int max_cyc, input int mode, input int stop_beats);
    beat_t e;
    for (int n = 0; n < max_cyc; n++) begin
      @(negedge clk);
      cyc++;
      if (mem_rd_en) begin
        rd_cnt++;
        if (fr < 0) fr = cyc;
        if (raise_acq) acq_busy = 1'b1;
        if (addr_q.size() != 0) chk("rd_addr", 32'(mem_rd_addr), 32'(addr_q.pop_front()));
        else chk("rd_unexpected", 32'(addr_q.size()), 32'd1);
      end
      if (busy) busy_seen++;
      if (out_valid && fv < 0) fv = cyc;
      if (prev_stall) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_beat", 32'({out_last, out_data}), 32'(prev_beat));
      end
      if (out_valid && out_ready) begin
        beat_cnt++;
        if (fhs < 0) fhs = cyc;
        if (out_last) lhs = cyc;
        if (beat_q.size() != 0) begin
          e = beat_q.pop_front();
          chk("beat_data", 32'(out_data), 32'(e.data));
          chk("beat_last", 32'(out_last), 32'(e.last));
        end else begin
          chk("beat_unexpected", 32'(beat_q.size()), 32'd1);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_beat = {out_last, out_data};
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        if (lhs >= 0) chk("done_timing", 32'(cyc), 32'(lhs + 1));
      end
      if (cfg_err) begin
        cfg_cnt++;
        if (cfg_cyc < 0) cfg_cyc = cyc;
      end
      start = 1'b0;
      abort = 1'b0;
      if (mode == 1 && done) break;
      if (mode == 2 && beat_cnt >= stop_beats) break;
    end
  endtask

  task automatic check_zero(input string t);
    chk({t, "_mem_rd_en"},   32'(mem_rd_en),   32'd0);
    chk({t, "_mem_rd_addr"}, 32'(mem_rd_addr), 32'd0);
    chk({t, "_out_valid"},   32'(out_valid),   32'd0);
    chk({t, "_out_last"},    32'(out_last),    32'd0);
    chk({t, "_out_data"},    32'(out_data),    32'd0);
    chk({t, "_busy"},        32'(busy),        32'd0);
    chk({t, "_done"},        32'(done),        32'd0);
    chk({t, "_cfg_err"},     32'(cfg_err),     32'd0);
  endtask

  initial begin
    int s;
    reset = 1'b1; start = 1'b0; abort = 1'b0; acq_busy = 1'b0;
    start_addr = '0; num_samples = '0;
    clear_stats();
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;

    // Basic readout at full throughput
    clear_stats();
    do_start(100, 5);
    run(60, 1, 0);
    chk("t1_beats", beat_cnt, 5);
    chk("t1_reads", rd_cnt, 5);
    chk("t1_done", done_cnt, 1);
    chk("t1_first_latency", 32'(fv - fr >= 2), 32'd1);
    chk("t1_throughput", 32'(lhs - fhs), 32'd4);
    chk("t1_busy_after", 32'(busy), 32'd0);
    chk("t1_queues", 32'(beat_q.size() + addr_q.size()), 32'd0);

    // Wrap at the end of memory
    clear_stats();
    do_start(102398, 4);
    run(60, 1, 0);
    chk("t2_beats", beat_cnt, 4);
    chk("t2_done", done_cnt, 1);
    chk("t2_queues", 32'(beat_q.size() + addr_q.size()), 32'd0);

    // Random backpressure
    clear_stats();
    rand_mode = 1'b1;
    do_start(5000, 64);
    run(2000, 1, 0);
    rand_mode = 1'b0;
    chk("t3_beats", beat_cnt, 64);
    chk("t3_reads", rd_cnt, 64);
    chk("t3_done", done_cnt, 1);
    chk("t3_queues", 32'(beat_q.size() + addr_q.size()), 32'd0);

    // Acquisition busy holds off reads; re-raising it later does not stall
    clear_stats();
    acq_busy = 1'b1;
    do_start(200, 3);
    run(20, 0, 0);
    chk("t4_no_reads", rd_cnt, 0);
    chk("t4_busy_wait", 32'(busy), 32'd1);
    acq_busy = 1'b0;
    raise_acq = 1'b1;
    run(60, 1, 0);
    raise_acq = 1'b0;
    acq_busy = 1'b0;
    chk("t4_beats", beat_cnt, 3);
    chk("t4_done", done_cnt, 1);

    // Out-of-range start address
    clear_stats();
    s = cyc;
    do_start(102400, 5);
    run(4, 0, 0);
    chk("t5_cfg_err", cfg_cnt, 1);
    chk("t5_cfg_timing", 32'(cfg_cyc - s), 32'd1);
    chk("t5_busy", busy_seen, 0);
    chk("t5_reads", rd_cnt, 0);

    // Zero-length request
    clear_stats();
    s = cyc;
    do_start(300, 0);
    run(4, 0, 0);
    chk("t6_done", done_cnt, 1);
    chk("t6_done_timing", 32'(done_cyc - s), 32'd1);
    chk("t6_reads", rd_cnt, 0);
    chk("t6_beats", beat_cnt, 0);

    // Abort at beat 10 of 50, with a simultaneous start that must be ignored
    clear_stats();
    do_start(1000, 50);
    run(200, 2, 10);
    chk("t7_beats_before", beat_cnt, 10);
    clear_stats();
    addr_q.delete();
    beat_q.delete();
    abort = 1'b1;
    start = 1'b1;
    start_addr = AW'(7);
    num_samples = AW'(5);
    run(1, 0, 0);
    chk("t7_busy", 32'(busy), 32'd0);
    chk("t7_out_valid", 32'(out_valid), 32'd0);
    run(10, 0, 0);
    chk("t7_no_done", done_cnt, 0);
    chk("t7_no_reads", rd_cnt, 0);
    chk("t7_no_beats", beat_cnt, 0);
    chk("t7_start_ignored", busy_seen, 0);

    // Reset in the middle of a readout
    clear_stats();
    do_start(2000, 50);
    run(200, 2, 3);
    reset = 1'b1;
    prev_stall = 1'b0;
    addr_q.delete();
    beat_q.delete();
    run(1, 0, 0);
    check_zero("mid_reset");
    reset = 1'b0;
    clear_stats();
    run(5, 0, 0);
    chk("t8_reads", rd_cnt, 0);
    chk("t8_beats", beat_cnt, 0);
    chk("t8_busy", busy_seen, 0);

`ifdef READOUT_DECIMATE_EN
    // Decimated readout with wrap
    clear_stats();
    decim_v = 4'd3;
    do_start(102396, 3);
    run(60, 1, 0);
    chk("t9_beats", beat_cnt, 3);
    chk("t9_done", done_cnt, 1);
    chk("t9_queues", 32'(beat_q.size() + addr_q.size()), 32'd0);
    decim_v = 4'd0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/capture_readout_controller.md
CAPTURE_READOUT_CONTROLLER -- requirements
Module: capture_readout_controller

Interface
REQ-001 Parameters SHALL be, one per line:
- DEPTH, 102400, sample memory depth in words.
- ADDR_W, 17, memory address width.
- DATA_W, 16, sample width.
REQ-002 clk  input  1  single clock; all logic on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to begin a readout.
REQ-005 abort  input  1  cancels an in-progress readout.
REQ-006 start_addr  input  ADDR_W  address of the first sample, sampled on start.
REQ-007 num_samples  input  ADDR_W  output beat count, sampled on start.
REQ-008 acq_busy  input  1  high while acquisition is writing sample memory.
REQ-009 mem_rd_en  output  1  memory read strobe.
REQ-010 mem_rd_addr  output  ADDR_W  memory read address.
REQ-011 mem_rd_data  input  DATA_W  read data, valid exactly 1 cycle after mem_rd_en.
REQ-012 out_data, out_valid, out_last  output  DATA_W/1/1  sample stream to the consumer.
REQ-013 out_ready  input  1  consumer accepts a beat when out_valid&&out_ready.
REQ-014 busy, done, cfg_err  output  1 each  status; done and cfg_err are one-cycle pulses.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT_ACQ, READ, DRAIN.
- IDLE -> WAIT_ACQ on a valid start.
- WAIT_ACQ -> READ on the first cycle with acq_busy low.
- READ -> DRAIN when the last read has issued.
- DRAIN -> IDLE on the out_last handshake.
REQ-016 A start with start_addr>=DEPTH SHALL pulse cfg_err the next cycle, stay IDLE, issue no reads.
REQ-017 A start with num_samples==0 SHALL pulse done the next cycle with no beats and no reads.
REQ-018 num_samples>DEPTH SHALL be clamped to DEPTH.
REQ-019 start SHALL be ignored outside IDLE.
REQ-020 busy SHALL be high in every state except IDLE.
REQ-021 Read address sequence:
- First read at start_addr.
- Next address = addr+stride, minus DEPTH if the sum is >=DEPTH.
- DEPTH-1 with stride 1 wraps to 0.
REQ-022 A read SHALL issue only when (skid occupancy + reads in flight) < 2 and beats remain to issue.
REQ-023 No sample SHALL ever be dropped or duplicated under any out_ready pattern.
REQ-024 With out_ready held high, throughput SHALL be one beat per cycle.
REQ-025 The first out_valid SHALL be no earlier than 2 cycles after entering READ.
REQ-026 out_data/out_valid/out_last SHALL hold stable while out_valid&&!out_ready.
REQ-027 out_last SHALL be high only on the num_samples-th beat.
REQ-028 done SHALL pulse the cycle after the out_last handshake.
REQ-029 abort in any non-IDLE state SHALL, next cycle: enter IDLE, flush the skid buffer, drop out_valid; it SHALL NOT pulse done; abort in IDLE has no effect.
REQ-030 acq_busy rising during READ/DRAIN SHALL NOT stall the readout; it is sampled only in WAIT_ACQ.
REQ-031 If abort and start arrive together, abort SHALL win and start SHALL be ignored.

Reset
REQ-032 Reset SHALL force state IDLE and zero the skid buffer and in-flight counters.
REQ-033 After reset, every output SHALL be 0: mem_rd_en, mem_rd_addr, out_valid, out_last, out_data, busy, done, cfg_err.
REQ-034 Reset asserted mid-readout SHALL take effect on the next edge with no further reads or beats.

Configuration
REQ-035 With READOUT_DECIMATE_EN defined, input decim [3:0] SHALL exist and be sampled on start.
- stride = decim+1.
- num_samples counts emitted beats.
- The wrap rule of REQ-021 applies.
REQ-036 Without READOUT_DECIMATE_EN, port decim SHALL be absent and stride fixed at 1.

Structure
REQ-037 Package readout_pkg SHALL hold the state enum, DEPTH, ADDR_W, DATA_W and the memory read-latency constant (1).
REQ-038 The 2-entry output buffer SHALL be sub-module readout_skid_buffer (valid/ready in and out, DATA_W+1 wide for data plus last).

Verification
REQ-039 start_addr=100, num_samples=5, out_ready=1 -> data from addresses 100..104, last on the 5th beat, done 1 cycle later.
REQ-040 start_addr=102398, num_samples=4 -> addresses 102398, 102399, 0, 1.
REQ-041 num_samples=64, out_ready toggled randomly 50% -> exactly 64 beats in order, no gaps or duplicates in address order.
REQ-042 start with acq_busy=1 for 20 cycles -> no mem_rd_en until acq_busy falls; start_addr=102400 -> cfg_err pulse, busy stays 0.
REQ-043 abort at beat 10 of 50 -> IDLE next cycle, out_valid=0, no done; reset during READ -> all outputs 0.
REQ-044 READOUT_DECIMATE_EN, decim=3, start_addr=102396, num_samples=3 -> addresses 102396, 0, 4.
